// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the register unit: round-robin arbitration between two
// requesters, registered one-hot enables, and a one-register-per-cycle clear.
module regfile_wr_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int NUM_REGS       = 32,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                clr_done,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [DATA_W-1:0]   reg_d
);

  // Handshake: a transfer happens on a cycle where valid && ready. Ready is
  // combinational and may depend on valid; valid must never depend on ready,
  // and a pending request must hold valid/addr/data stable until accepted.

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int               CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic                rr_b_q, rr_b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
  logic [DATA_W-1:0]   reg_d_q, reg_d_d;
  logic                clr_done_q, clr_done_d;
  logic                arb_open;
  logic                grant_a;
  logic                grant_b;

  // Indices at or beyond NUM_REGS match no bit and so yield an all-zero vector.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [CNT_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      v[i] = (idx == CNT_W'(i));
    end
    return v;
  endfunction

  function automatic logic [NUM_REGS-1:0] wr_enable(input logic [ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v = onehot({1'b0, addr});
    if ((ZERO_HARDWIRED != 0) && (addr == '0)) begin
      v = '0;
    end
    return v;
  endfunction

  // rr_b_q=1 means B wins a tie; readies are held low while reset is applied.
  always_comb begin
    arb_open = rst_n && (state_q == ST_ARB) && !clr_req;
    grant_a  = arb_open && a_valid && (!b_valid || !rr_b_q);
    grant_b  = arb_open && b_valid && (!a_valid || rr_b_q);
  end

  always_comb begin
    state_d    = state_q;
    rr_b_d     = rr_b_q;
    cnt_d      = cnt_q;
    reg_en_d   = '0;
    reg_d_d    = reg_d_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (grant_a) begin
          reg_en_d = wr_enable(a_addr);
          reg_d_d  = a_data;
          rr_b_d   = 1'b1;
        end else if (grant_b) begin
          reg_en_d = wr_enable(b_addr);
          reg_d_d  = b_data;
          rr_b_d   = 1'b0;
        end
      end
      ST_CLEAR: begin
        reg_en_d = onehot(cnt_q);
        reg_d_d  = '0;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d    = ST_ARB;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ARB;
      rr_b_q     <= 1'b0;
      cnt_q      <= '0;
      reg_en_q   <= '0;
      reg_d_q    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_b_q     <= rr_b_d;
      cnt_q      <= cnt_d;
      reg_en_q   <= reg_en_d;
      reg_d_q    <= reg_d_d;
      clr_done_q <= clr_done_d;
    end
  end

  assign a_ready  = grant_a;
  assign b_ready  = grant_b;
  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = clr_done_q;
  assign reg_en   = reg_en_q;
  assign reg_d    = reg_d_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of arbitration and clearing.
module tb_regfile_wr_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZH       = 1;
  localparam int EXP_W    = NUM_REGS + DATA_W + 2;

  logic                clk;
  logic                rst_n;
  logic                a_valid, a_ready;
  logic [ADDR_W-1:0]   a_addr;
  logic [DATA_W-1:0]   a_data;
  logic                b_valid, b_ready;
  logic [ADDR_W-1:0]   b_addr;
  logic [DATA_W-1:0]   b_data;
  logic                clr_req, clr_busy, clr_done;
  logic [NUM_REGS-1:0] reg_en;
  logic [DATA_W-1:0]   reg_d;

  int checks;
  int failures;

  logic [EXP_W-1:0] exp_q[$];

  // Reference model state: clearing flag, next index to clear, tie winner, bus value.
  bit               m_clear;
  int               m_idx;
  bit               m_b_first;
  logic [DATA_W-1:0] m_last_d;

  regfile_wr_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .ZERO_HARDWIRED(ZH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done),
    .reg_en(reg_en), .reg_d(reg_d)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  function automatic logic [NUM_REGS-1:0] exp_enable(input logic [ADDR_W-1:0] addr);
    int ia;
    ia = int'(addr);
    if ((ZH != 0 && ia == 0) || ia >= NUM_REGS) return '0;
    return NUM_REGS'(64'd1 << ia);
  endfunction

  task automatic model_reset();
    m_clear   = 1'b0;
    m_idx     = 0;
    m_b_first = 1'b0;
    m_last_d  = '0;
  endtask

  // Driver: applies one cycle of stimulus, checks readies, pushes the expected
  // post-edge outputs for the monitor.
  task automatic step(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                      input bit bv, input logic [ADDR_W-1:0] ba, input logic [DATA_W-1:0] bd,
                      input bit cr, output bit ga, output bit gb);
    logic [NUM_REGS-1:0] e_en;
    bit                  e_done;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    clr_req = cr;
    #1;
    ga = 1'b0;
    gb = 1'b0;
    if (!m_clear && !cr) begin
      if (av && (!bv || !m_b_first)) ga = 1'b1;
      else if (bv) gb = 1'b1;
    end
    checks++;
    if ({a_ready, b_ready} !== {ga, gb}) begin
      failures++;
      $display("FAIL ready t=%0t got a=%b b=%b want a=%b b=%b", $time, a_ready, b_ready, ga, gb);
    end
    e_en   = '0;
    e_done = 1'b0;
    if (m_clear) begin
      e_en     = NUM_REGS'(64'd1 << m_idx);
      m_last_d = '0;
      e_done   = (m_idx == NUM_REGS - 1);
      m_idx++;
      if (m_idx == NUM_REGS) m_clear = 1'b0;
    end else if (cr) begin
      m_clear = 1'b1;
      m_idx   = 0;
    end else if (ga) begin
      e_en      = exp_enable(aa);
      m_last_d  = ad;
      m_b_first = 1'b1;
    end else if (gb) begin
      e_en      = exp_enable(ba);
      m_last_d  = bd;
      m_b_first = 1'b0;
    end
    exp_q.push_back({e_en, m_last_d, e_done, m_clear});
  endtask

  task automatic idle(input int n);
    bit ga, gb;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, ga, gb);
  endtask

  // Reset is applied asynchronously mid-cycle; valids are raised to confirm
  // readies stay low while reset is active.
  task automatic apply_reset(input int n);
    @(negedge clk);
    #2;
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; clr_req = 1'b0;
    #1;
    checks++;
    if ({a_ready, b_ready, clr_busy, clr_done} !== 4'b0 || reg_en !== '0 || reg_d !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ar=%b br=%b busy=%b done=%b en=%h d=%h want all zero",
               a_ready, b_ready, clr_busy, clr_done, reg_en, reg_d);
    end
    exp_q.delete();
    model_reset();
    repeat (n) @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n   = 1'b1;
  endtask

  // Monitor / scoreboard: every post-edge sample pops one expected entry.
  always @(posedge clk) begin
    logic [EXP_W-1:0] e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({reg_en, reg_d, clr_done, clr_busy} !== e) begin
        failures++;
        $display("FAIL outputs t=%0t got en=%h d=%h done=%b busy=%b want en=%h d=%h done=%b busy=%b",
                 $time, reg_en, reg_d, clr_done, clr_busy,
                 e[EXP_W-1 -: NUM_REGS], e[DATA_W+1:2], e[1], e[0]);
      end
    end
  end

  initial begin
    bit ga, gb;
    bit pa, pb, cr;
    logic [ADDR_W-1:0] aa, ba;
    logic [DATA_W-1:0] ad, bd;
    int n;

    checks = 0; failures = 0;
    rst_n = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    clr_req = 1'b0;
    model_reset();
    apply_reset(2);

    // Single A write then idle
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, ga, gb);
    idle(2);

    // Contention from a fresh reset: A,B,A,B
    apply_reset(1);
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd1, 32'h1000 + i, 1'b1, 5'd2, 32'h2000 + i, 1'b0, ga, gb);
    idle(1);

    // Write to index 0 is accepted, no enable
    step(1'b1, 5'd0, 32'h1234, 1'b0, '0, '0, 1'b0, ga, gb);
    idle(1);

    // Clear while A is pending; A is granted in the cycle of clr_done
    step(1'b1, 5'd7, 32'hCAFE0007, 1'b0, '0, '0, 1'b1, ga, gb);
    n = 0; ga = 1'b0;
    while (!ga && n < 40) begin
      step(1'b1, 5'd7, 32'hCAFE0007, 1'b0, '0, '0, 1'b0, ga, gb);
      n++;
    end
    checks++;
    if (n != NUM_REGS + 1) begin
      failures++;
      $display("FAIL clr_grant_latency got %0d want %0d", n, NUM_REGS + 1);
    end
    idle(2);

    // Reset in the middle of a clear
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, ga, gb);
    idle(11);
    apply_reset(1);
    idle(2);
    step(1'b1, 5'd3, 32'h33333333, 1'b0, '0, '0, 1'b0, ga, gb);
    checks++;
    if (!ga || a_ready !== 1'b1) begin
      failures++;
      $display("FAIL grant_after_reset got a_ready=%b want 1", a_ready);
    end
    idle(1);

    // B alone, descending top addresses
    for (int i = 0; i < 3; i++)
      step(1'b0, '0, '0, 1'b1, 5'(31 - i), 32'hB0000000 + i, 1'b0, ga, gb);
    idle(1);

    // Random traffic; pending requests hold until accepted
    pa = 1'b0; pb = 1'b0;
    aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa) begin
        pa = ($urandom_range(0, 2) != 0);
        aa = 5'($urandom_range(0, 31));
        ad = $urandom;
      end
      if (!pb) begin
        pb = ($urandom_range(0, 2) != 0);
        ba = 5'($urandom_range(0, 31));
        bd = $urandom;
      end
      cr = ($urandom_range(0, 39) == 0);
      step(pa, aa, ad, pb, ba, bd, cr, ga, gb);
      if (ga) pa = 1'b0;
      if (gb) pb = 1'b0;
    end
    idle(2);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Owns the single write port of the 32 x 32-bit register unit.
- Arbitrates between two write requesters, A (ALU/writeback) and B (load/CSR return), using valid/ready handshakes and round-robin priority.
- Drives a registered one-hot vector of per-register write enables plus a shared data bus.
- Contains a clear sequencer that writes zero to every register, one per cycle, on request.

Parameters:
- DATA_W, 32, width of the register data bus.
- ADDR_W, 5, width of the register index.
- NUM_REGS, 32, number of registers driven; must be <= 2**ADDR_W.
- ZERO_HARDWIRED, 1, when 1, requester writes to index 0 are accepted but produce no enable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a_valid  input  1  requester A has a write pending.
- a_ready  output  1  requester A is granted this cycle.
- a_addr  input  ADDR_W  destination index from A.
- a_data  input  DATA_W  write data from A.
- b_valid  input  1  requester B has a write pending.
- b_ready  output  1  requester B is granted this cycle.
- b_addr  input  ADDR_W  destination index from B.
- b_data  input  DATA_W  write data from B.
- clr_req  input  1  request a full register clear; level, sampled only in ARB.
- clr_busy  output  1  clear sequence in progress.
- clr_done  output  1  single-cycle pulse marking the final clear write.
- reg_en  output  NUM_REGS  per-register write enable, one-hot or all zero.
- reg_d  output  DATA_W  shared write data bus to all registers.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=ARB, rr_ptr=A, clear counter=0.
  - reg_en=0, reg_d=0, clr_done=0, clr_busy=0, a_ready=b_ready=0.
- States: ARB and CLEAR.
- Ready generation:
  - a_ready and b_ready are combinational from state, the valids, clr_req and rr_ptr.
  - Ready may depend on valid. Requesters must not make valid depend on ready.
- Arbitration in ARB with clr_req=0:
  - Only a_valid set: a_ready=1.
  - Only b_valid set: b_ready=1.
  - Both set: the side selected by rr_ptr gets ready; the other stays 0.
  - After any grant, rr_ptr points to the non-granted side.
  - At most one ready is high per cycle.
- Transfer and write latency:
  - A transfer occurs on valid && ready.
  - At the next edge, reg_d <= data and reg_en <= one-hot(addr), giving 1-cycle latency.
  - reg_en is dropped to 0 (transfer still completes) if addr >= NUM_REGS, or if addr==0 and ZERO_HARDWIRED=1.
  - reg_d updates on every completed transfer, dropped writes included.
- Idle cycles:
  - With no transfer and not in CLEAR, reg_en <= 0, so enables are single-cycle pulses.
  - reg_d holds its last value.
- Clear takes priority:
  - clr_req=1 in ARB suppresses both readies that cycle (cycle T).
  - State moves to CLEAR at T+1 with counter=0.
  - A request pending at T stays pending and must remain stable.
- CLEAR operation:
  - Each cycle, reg_en <= one-hot(counter), reg_d <= 0, counter <= counter+1.
  - Index 0 is included regardless of ZERO_HARDWIRED.
  - clr_busy = (state==CLEAR): high for cycles T+1 .. T+NUM_REGS.
  - Both readies are 0 throughout.
  - The enable for register k is visible in cycle T+2+k.
- Clear completion:
  - On the cycle issuing counter=NUM_REGS-1, state returns to ARB.
  - clr_done is registered and high only in cycle T+NUM_REGS+1, together with the last enable.
  - Grants resume in that same cycle.
  - clr_req held high re-triggers a clear the cycle it is sampled in ARB.
- clr_req during CLEAR is ignored and not queued.
- Counter wrap: the counter is ADDR_W+1 bits wide, so it never wraps before exit. It is reset to 0 on entry.
- Reset mid-CLEAR: state goes immediately to ARB and reg_en=0. The clear is not resumed, and no clr_done is produced.
- Width rules:
  - Addresses are compared unsigned against NUM_REGS.
  - Data passes through unmodified.

Test Plan:
- Reset, then a_valid=1, a_addr=5, a_data=0xDEADBEEF, b_valid=0 -> a_ready=1 same cycle. Next cycle reg_en=0x00000020, reg_d=0xDEADBEEF. The following cycle reg_en=0.
- a_valid=b_valid=1 held for 4 cycles (a_addr=1, b_addr=2) -> grants alternate A,B,A,B. reg_en sequence 0x2,0x4,0x2,0x4, each one cycle after its grant. Never two readies together.
- a_addr=0, a_data=0x1234 with ZERO_HARDWIRED=1 -> a_ready=1, reg_en stays 0, reg_d=0x1234 next cycle.
- clr_req=1 for one cycle at T while a_valid=1 -> a_ready=0 at T. clr_busy high T+1..T+32. reg_en=1<<k at T+2+k with reg_d=0. clr_done=1 only at T+33. a_ready=1 at T+33.
- Start clear, assert rst_n=0 at counter=10 -> reg_en=0 and clr_busy=0 immediately. After release, state is ARB, no clr_done, and a fresh a_valid is granted.
- b_valid held alone 3 cycles with addresses 31,30,29 -> b_ready=1 each cycle. reg_en=0x80000000, 0x40000000, 0x20000000 on consecutive cycles.
